sign_mag_acc: RTL



---
 rtl/sign_mag_acc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sign_mag_acc.sv
// rtl/sign_mag_acc.sv - sequential sign-magnitude accumulator (accept / compare / add)
//
// Adds one sign-magnitude operand per handshake into a registered
// sign-magnitude running total. Each operand takes three states:
// IDLE (accept), CMP (order magnitudes, pick result sign), ADD (add or
// subtract magnitudes, write acc).
//
// Optional feature macro: SIGN_MAG_ACC_SAT_EN
//   defined     -> magnitude saturates to 2^(N-1)-1 on overflow
//   not defined -> magnitude wraps modulo 2^(N-1)
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   clr       synchronous clear of acc/ovf/done, aborts any in-flight operand
//   in_valid  operand present on in_data
//   in_ready  high in IDLE, block can accept an operand
//   in_data   N-bit sign-magnitude operand (MSB = sign)
//   acc       N-bit sign-magnitude accumulated total, zero always stored as +0
//   done      one-cycle pulse when acc has just been updated
//   ovf       sticky magnitude-overflow flag

module sign_mag_acc #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] acc,
  output logic         done,
  output logic         ovf
);

  localparam int M = N - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_ADD
  } state_t;

  state_t state, next_state;

  logic         op_sign;
  logic [M-1:0] op_mag;
  logic [M-1:0] max_mag;
  logic [M-1:0] min_mag;
  logic         res_sign;
  logic         same_sign;

  logic         accept;
  logic         acc_sign;
  logic [M-1:0] acc_mag;
  logic [N-1:0] sum;
  logic [M-1:0] diff;
  logic         add_ovf;
  logic [M-1:0] res_mag;

  assign acc_sign = acc[N-1];
  assign acc_mag  = acc[M-1:0];
  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) next_state = S_CMP;
        S_CMP:   next_state = S_ADD;
        S_ADD:   next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Magnitude arithmetic; the sum keeps one extra bit so the carry out of
  // the magnitude field is visible as the overflow indication.
  always_comb begin
    sum     = {1'b0, max_mag} + {1'b0, min_mag};
    diff    = max_mag - min_mag;
    add_ovf = same_sign && sum[M];
    res_mag = diff;
    if (same_sign) begin
`ifdef SIGN_MAG_ACC_SAT_EN
      res_mag = add_ovf ? {M{1'b1}} : sum[M-1:0];
`else
      res_mag = sum[M-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      op_sign   <= 1'b0;
      op_mag    <= '0;
      max_mag   <= '0;
      min_mag   <= '0;
      res_sign  <= 1'b0;
      same_sign <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // -0 on the input is folded to +0 so it never flips the sign logic
        op_sign <= in_data[N-1] && (|in_data[M-1:0]);
        op_mag  <= in_data[M-1:0];
      end
      if (state == S_CMP) begin
        same_sign <= (acc_sign == op_sign);
        if (acc_mag >= op_mag) begin
          max_mag  <= acc_mag;
          min_mag  <= op_mag;
          res_sign <= acc_sign;
        end else begin
          max_mag  <= op_mag;
          min_mag  <= acc_mag;
          res_sign <= op_sign;
        end
      end
      if (state == S_ADD) begin
        // A zero magnitude (tie with opposite signs, or wrap to 0) is stored as +0
        acc  <= {res_sign && (|res_mag), res_mag};
        ovf  <= ovf || add_ovf;
        done <= 1'b1;
      end
    end
  end

endmodule
